// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave with NUM_REGS 32-bit read/write control registers.
// Register contents are exported on reg_out with a one-cycle reg_wr_pulse per write.
// Write and read channels run independent state machines.
// Optional feature macro AXIL_REGFILE_ERR_EN: when defined, out-of-range accesses return
// SLVERR (writes discarded, reads return 0); otherwise addresses alias modulo NUM_REGS*4.
`timescale 1ns / 1ps

module axi_lite_regfile #(
   parameter int unsigned NUM_REGS         = 8,
   parameter int unsigned S_AXI_DATA_WIDTH = 32,
   parameter int unsigned S_AXI_STRB_WIDTH = S_AXI_DATA_WIDTH / 8
) (
   input  logic                                   s_axi_aclk,
   input  logic                                   s_axi_aresetn,
   input  logic [31:0]                            s_axi_awaddr,
   input  logic                                   s_axi_awvalid,
   output logic                                   s_axi_awready,
   input  logic [S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
   input  logic [S_AXI_STRB_WIDTH-1:0]            s_axi_wstrb,
   input  logic                                   s_axi_wvalid,
   output logic                                   s_axi_wready,
   output logic [1:0]                             s_axi_bresp,
   output logic                                   s_axi_bvalid,
   input  logic                                   s_axi_bready,
   input  logic [31:0]                            s_axi_araddr,
   input  logic                                   s_axi_arvalid,
   output logic                                   s_axi_arready,
   output logic [S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
   output logic [1:0]                             s_axi_rresp,
   output logic                                   s_axi_rvalid,
   input  logic                                   s_axi_rready,
   output logic [NUM_REGS*S_AXI_DATA_WIDTH-1:0]   reg_out,
   output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_EXEC = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]                  wstate;
   logic                        rstate;
   logic                        aw_held;
   logic                        w_held;
   logic [31:0]                 aw_addr;
   logic [31:0]                 ar_addr;
   logic [S_AXI_DATA_WIDTH-1:0] w_data;
   logic [S_AXI_STRB_WIDTH-1:0] w_strb;
   logic [S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]            w_idx;
   logic [IDX_W-1:0]            r_idx;
   logic                        w_ok;
   logic                        r_ok;
   logic                        aw_hs;
   logic                        w_hs;
   logic                        ar_hs;
   logic                        aw_next;
   logic                        w_next;

   assign w_idx = aw_addr[2 +: IDX_W];
   assign r_idx = ar_addr[2 +: IDX_W];

`ifdef AXIL_REGFILE_ERR_EN
   localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
   logic unused_addr_bits;
   // Full 32-bit compare so high address bits cannot alias into the register space
   assign w_ok = (aw_addr < ADDR_LIMIT);
   assign r_ok = (ar_addr < ADDR_LIMIT);
   assign unused_addr_bits = ^{aw_addr[1:0], ar_addr[1:0]};
`else
   logic unused_addr_bits;
   // No range check: index bits alone select the register
   assign w_ok = 1'b1;
   assign r_ok = 1'b1;
   assign unused_addr_bits = ^{aw_addr[31:IDX_W+2], aw_addr[1:0],
                               ar_addr[31:IDX_W+2], ar_addr[1:0]};
`endif

   assign aw_hs   = s_axi_awvalid & s_axi_awready;
   assign w_hs    = s_axi_wvalid & s_axi_wready;
   assign ar_hs   = s_axi_arvalid & s_axi_arready;
   assign aw_next = aw_held | aw_hs;
   assign w_next  = w_held | w_hs;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign reg_out[i*S_AXI_DATA_WIDTH +: S_AXI_DATA_WIDTH] = regs[i];
   end

   // Write channel FSM: latch AW and W independently, execute once both are held
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wstate        <= W_IDLE;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         reg_wr_pulse  <= '0;
      end else begin
         reg_wr_pulse <= '0;
         case (wstate)
            W_IDLE: begin
               if (aw_hs) aw_addr <= s_axi_awaddr;
               if (w_hs) begin
                  w_data <= s_axi_wdata;
                  w_strb <= s_axi_wstrb;
               end
               aw_held       <= aw_next;
               w_held        <= w_next;
               // Also raises the readies on the first edge after reset release
               s_axi_awready <= ~aw_next;
               s_axi_wready  <= ~w_next;
               if (aw_next && w_next) wstate <= W_EXEC;
            end
            W_EXEC: begin
               if (w_ok) reg_wr_pulse[w_idx] <= 1'b1;
               s_axi_bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
               s_axi_bvalid <= 1'b1;
               wstate       <= W_RESP;
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  s_axi_wready  <= 1'b1;
                  aw_held       <= 1'b0;
                  w_held        <= 1'b0;
                  wstate        <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   // Register array: byte-wise update during the single execute cycle
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wstate == W_EXEC && w_ok) begin
         for (int k = 0; k < S_AXI_STRB_WIDTH; k++) begin
            if (w_strb[k]) regs[w_idx][8*k +: 8] <= w_data[8*k +: 8];
         end
      end
   end

   // Read channel FSM: latch AR, load data one edge later, hold until rready
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rstate        <= R_IDLE;
         ar_addr       <= '0;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
      end else if (rstate == R_IDLE) begin
         if (ar_hs) begin
            ar_addr       <= s_axi_araddr;
            s_axi_arready <= 1'b0;
            rstate        <= R_DATA;
         end else begin
            s_axi_arready <= 1'b1;
         end
      end else begin
         if (!s_axi_rvalid) begin
            // Sampled with pre-write contents if a write lands on the same edge
            s_axi_rdata  <= r_ok ? regs[r_idx] : '0;
            s_axi_rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
         end else if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rstate        <= R_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: table-driven bench with response scoreboard for axi_lite_regfile.
// Honours AXIL_REGFILE_ERR_EN for the out-of-range expectations.
`timescale 1ns / 1ps

module tb_axi_lite_regfile;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [255:0] reg_out;
   logic [7:0]   reg_wr_pulse;

   always #5 clk = ~clk;

   axi_lite_regfile #(.NUM_REGS(8)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .reg_out       (reg_out),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic [7:0]  exp_pulse;
   } vec_t;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];
   logic [33:0] mon_r;
   logic [7:0]  pulse_seen;
   int          pulse_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic [7:0] exp_pulse);
      bit a_done, w_done, a_hs, w_hs;
      int cyc, lat;
      a_done = 0; w_done = 0; cyc = 0;
      pulse_seen = '0; pulse_cnt = 0;
      bq.push_back(exp_resp);
      @(posedge clk); #1;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      while (!(a_done && w_done) && cyc < 20) begin
         @(negedge clk);
         a_hs = awvalid && awready;
         w_hs = wvalid && wready;
         @(posedge clk); #1;
         if (a_hs) begin awvalid = 1'b0; a_done = 1; end
         if (w_hs) begin wvalid = 1'b0; w_done = 1; end
         cyc++;
      end
      if (!(a_done && w_done)) begin
         chk({tag, "_accept_timeout"}, 0, 1);
         awvalid = 1'b0; wvalid = 1'b0;
         bq.delete();
         return;
      end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bvalid && lat < 10);
      chk({tag, "_bvalid_latency"}, lat, 2);
      cyc = 0;
      while (bq.size() != 0 && cyc < 10) begin @(negedge clk); cyc++; end
      chk({tag, "_bresp_seen"}, bq.size(), 0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, pulse_seen, exp_pulse);
      chk({tag, "_pulse_cycles"}, pulse_cnt, (exp_pulse != 0) ? 1 : 0);
   endtask

   task automatic axi_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit done;
      int cyc, lat;
      done = 0; cyc = 0;
      rq.push_back({exp_resp, exp_data});
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         done = arvalid && arready;
         @(posedge clk); #1;
         cyc++;
      end
      arvalid = 1'b0;
      if (!done) begin
         chk({tag, "_ar_timeout"}, 0, 1);
         rq.delete();
         return;
      end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rvalid && lat < 10);
      chk({tag, "_rvalid_latency"}, lat, 2);
      cyc = 0;
      while (rq.size() != 0 && cyc < 10) begin @(negedge clk); cyc++; end
      chk({tag, "_rdata_seen"}, rq.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vt[11];
      int   bad;
      logic [31:0] held;

      vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 8'h02};
      vt[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 8'h00};
      vt[2]  = '{1'b1, 32'h04, 32'h12345678, 4'h3, 32'h0,        2'b00, 8'h02};
      vt[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEAD5678, 2'b00, 8'h00};
      vt[4]  = '{1'b1, 32'h08, 32'hCAFEF00D, 4'h0, 32'h0,        2'b00, 8'h04};
      vt[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        2'b00, 8'h00};
      vt[6]  = '{1'b1, 32'h0E, 32'h01020304, 4'hC, 32'h0,        2'b00, 8'h08};
      vt[7]  = '{1'b0, 32'h0F, 32'h0,        4'h0, 32'h01020000, 2'b00, 8'h00};
`ifdef AXIL_REGFILE_ERR_EN
      vt[8]  = '{1'b1, 32'h20, 32'h11,       4'hF, 32'h0,        2'b10, 8'h00};
      vt[9]  = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h0,        2'b10, 8'h00};
      vt[10] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        2'b00, 8'h00};
`else
      vt[8]  = '{1'b1, 32'h20, 32'h11,       4'hF, 32'h0,        2'b00, 8'h01};
      vt[9]  = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h11,       2'b00, 8'h00};
      vt[10] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h11,       2'b00, 8'h00};
`endif

      rst_n = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      pulse_seen = '0; pulse_cnt = 0;

      // Scoreboard monitor: pops expected responses on each handshake
      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (reg_wr_pulse != 0) begin
                  pulse_seen |= reg_wr_pulse;
                  pulse_cnt++;
               end
               if (bvalid && bready) begin
                  if (bq.size() == 0) chk("bresp_unexpected", 1, 0);
                  else chk("bresp", bresp, bq.pop_front());
               end
               if (rvalid && rready) begin
                  if (rq.size() == 0) chk("rdata_unexpected", 1, 0);
                  else begin
                     mon_r = rq.pop_front();
                     chk("rdata", rdata, mon_r[31:0]);
                     chk("rresp", rresp, mon_r[33:32]);
                  end
               end
            end
         end
      join_none

      // Reset
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
      chk("reset_data", {rdata, reg_wr_pulse}, 0);
      chk("reset_regs", reg_out == '0, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_ready_before_edge", {awready, wready, arready}, 3'b000);
      @(negedge clk);
      chk("release_ready_after_edge", {awready, wready, arready}, 3'b111);
      chk("release_regs", reg_out == '0, 1);

      // Table-driven transactions
      for (int i = 0; i < 11; i++) begin
         if (vt[i].wr)
            axi_write($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb,
                      vt[i].exp_resp, vt[i].exp_pulse);
         else
            axi_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp_data, vt[i].exp_resp);
      end
      chk("regout_r1", reg_out[63:32], 32'hDEAD5678);
`ifdef AXIL_REGFILE_ERR_EN
      chk("regout_r0", reg_out[31:0], 32'h0);
`else
      chk("regout_r0", reg_out[31:0], 32'h11);
`endif

      // Channel skew: W three cycles ahead of AW
      pulse_seen = '0; pulse_cnt = 0;
      bq.push_back(2'b00);
      @(posedge clk); #1;
      wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      chk("skew_wready_pre", wready, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (wready !== 1'b0 || bvalid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("skew_wready_dropped", bad, 0);
      awaddr = 32'h1C; awvalid = 1'b1;
      @(negedge clk);
      chk("skew_aw_ready", {awready, wready}, 2'b10);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      chk("skew_bvalid_early", bvalid, 0);
      @(negedge clk);
      chk("skew_bvalid", bvalid, 1);
      chk("skew_reg7", reg_out[255:224], 32'hA5A5A5A5);
      @(posedge clk); #1;
      @(negedge clk);
      chk("skew_ready_back", {awready, wready, bvalid}, 3'b110);
      chk("skew_pulse", pulse_seen, 8'h80);
      chk("skew_pulse_cycles", pulse_cnt, 1);

      // Backpressure on B
      bready = 1'b0;
      @(posedge clk); #1;
      awaddr = 32'h10; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("bp_w_accept", {awready, wready}, 2'b11);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) bad++;
      end
      chk("bp_write_hold", bad, 0);
      bq.push_back(2'b00);
      @(posedge clk); #1;
      bready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_write_release", {awready, wready, bvalid}, 3'b110);

      // Backpressure on R
      rready = 1'b0;
      @(posedge clk); #1;
      araddr = 32'h10; arvalid = 1'b1;
      @(negedge clk);
      chk("bp_ar_accept", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_rvalid", rvalid, 1);
      held = rdata;
      chk("bp_rdata", held, 32'h55AA55AA);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!(rvalid === 1'b1 && rdata === 32'h55AA55AA && rresp === 2'b00 && arready === 1'b0))
            bad++;
      end
      chk("bp_read_hold", bad, 0);
      rq.push_back({2'b00, 32'h55AA55AA});
      @(posedge clk); #1;
      rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_read_release", {arready, rvalid}, 2'b10);

      // Reset in the middle of a pending write response
      bready = 1'b0;
      @(posedge clk); #1;
      awaddr = 32'h04; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_bvalid", bvalid, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_reset_ctrl", {bvalid, awready, wready, arready}, 0);
      chk("mid_reset_regs", reg_out == '0, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bready = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bvalid !== 1'b0) bad++;
      end
      chk("mid_no_response", bad, 0);
      chk("mid_ready_back", {awready, wready, arready}, 3'b111);
      axi_read("mid_read", 32'h04, 32'h0, 2'b00);
      axi_read("mid_read7", 32'h1C, 32'h0, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
